// File: rtl/acc_ctrl_pkg.sv
// Shared types, default parameters and counter sizing for the multi-user
// access controller.
package acc_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GET_PW,
      WAIT_MEM,
      CHECK,
      GRANT,
      LOCKOUT,
      CHANGE_WAIT,
      CHANGE_WR
   } state_e;

   localparam int DEF_PW_W        = 16;
   localparam int DEF_ID_W        = 8;
   localparam int DEF_MAX_FAIL    = 3;
   localparam int DEF_LOCK_CYCLES = 1024;
   localparam int DEF_MEM_LAT     = 1;

   // Width of a down-counter that must hold either of two load values.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/acc_lock_timer.sv
// Loadable down-counter that stops at zero; zero is flagged from the
// registered count.
module acc_lock_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = value;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/access_ctrl_multi.sv
// Multi-user access controller: checks a user's password against an external
// RAM, counts consecutive failures, locks out for a while, and supports change.
module access_ctrl_multi
   import acc_ctrl_pkg::*;
#(
   parameter int PW_W        = DEF_PW_W,
   parameter int ID_W        = DEF_ID_W,
   parameter int MAX_FAIL    = DEF_MAX_FAIL,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
   parameter int MEM_LAT     = DEF_MEM_LAT
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PW_W-1:0]                  data_in,
   input  logic                             data_in_load,
   input  logic                             logout,
   input  logic [PW_W-1:0]                  mem_rd_data,
   output logic [ID_W-1:0]                  mem_addr,
   output logic                             mem_wren,
   output logic [PW_W-1:0]                  mem_wr_data,
   output logic                             access_grant,
   output logic                             locked_out,
   output logic [$clog2(MAX_FAIL+1)-1:0]    fail_count
);

   localparam int FC_W  = $clog2(MAX_FAIL + 1);
   localparam int CNT_W = cnt_width(MEM_LAT, LOCK_CYCLES - 1);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   addr_q, addr_d;
   logic              chg_q, chg_d;
   logic [PW_W-1:0]   pw_q, pw_d;
   logic [PW_W-1:0]   mem_q, mem_d;
   logic [FC_W-1:0]   fail_q, fail_d;
   logic              grant_q, grant_d;
   logic              lock_q, lock_d;
   logic              wren_q, wren_d;
   logic [PW_W-1:0]   wr_data_q, wr_data_d;

   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_value;
   logic              tmr_zero;

   acc_lock_timer #(.W(CNT_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_value),
      .zero  (tmr_zero)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      chg_d     = chg_q;
      pw_d      = pw_q;
      mem_d     = mem_q;
      fail_d    = fail_q;
      grant_d   = grant_q;
      lock_d    = lock_q;
      wren_d    = 1'b0;
      wr_data_d = wr_data_q;
      tmr_load  = 1'b0;
      tmr_value = '0;
      case (state_q)
         IDLE: begin
            if (data_in_load) begin
               addr_d  = data_in[ID_W-1:0];
               chg_d   = data_in[ID_W];
               state_d = GET_PW;
            end
         end
         GET_PW: begin
            if (data_in_load) begin
               pw_d      = data_in;
               tmr_load  = 1'b1;
               tmr_value = CNT_W'(MEM_LAT);
               state_d   = WAIT_MEM;
            end
         end
         // First WAIT_MEM cycle issues the read; data is taken MEM_LAT cycles later.
         WAIT_MEM: begin
            if (tmr_zero) begin
               mem_d   = mem_rd_data;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (pw_q == mem_q) begin
               fail_d  = '0;
               grant_d = ~chg_q;
               state_d = chg_q ? CHANGE_WAIT : GRANT;
            end else begin
               fail_d = fail_q + 1'b1;
               if (fail_q + 1'b1 == FC_W'(MAX_FAIL)) begin
                  lock_d    = 1'b1;
                  tmr_load  = 1'b1;
                  tmr_value = CNT_W'(LOCK_CYCLES - 1);
                  state_d   = LOCKOUT;
               end else begin
                  state_d = GET_PW;
               end
            end
         end
         GRANT: begin
            grant_d = 1'b1;
            if (logout) begin
               grant_d = 1'b0;
               state_d = IDLE;
            end
         end
         LOCKOUT: begin
            if (tmr_zero) begin
               lock_d  = 1'b0;
               fail_d  = '0;
               state_d = IDLE;
            end
         end
         CHANGE_WAIT: begin
            if (data_in_load) begin
               wr_data_d = data_in;
               wren_d    = 1'b1;
               state_d   = CHANGE_WR;
            end
         end
         CHANGE_WR: begin
            state_d = IDLE;
         end
         default: begin
            grant_d = 1'b0;
            lock_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         chg_q     <= 1'b0;
         pw_q      <= '0;
         mem_q     <= '0;
         fail_q    <= '0;
         grant_q   <= 1'b0;
         lock_q    <= 1'b0;
         wren_q    <= 1'b0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         chg_q     <= chg_d;
         pw_q      <= pw_d;
         mem_q     <= mem_d;
         fail_q    <= fail_d;
         grant_q   <= grant_d;
         lock_q    <= lock_d;
         wren_q    <= wren_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign mem_addr     = addr_q;
   assign mem_wren     = wren_q;
   assign mem_wr_data  = wr_data_q;
   assign access_grant = grant_q;
   assign locked_out   = lock_q;
   assign fail_count   = fail_q;

endmodule

// File: tb/tb_access_ctrl_multi.sv
// Self-checking bench for access_ctrl_multi: default instance plus a MEM_LAT=3
// instance, each with a small password-RAM model holding user 5.
module tb_access_ctrl_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] data_in = 16'h0;
   logic        data_in_load = 1'b0;
   logic        logout = 1'b0;

   logic [15:0] mem_rd_data_a, mem_wr_data_a;
   logic [7:0]  mem_addr_a;
   logic        mem_wren_a, access_grant_a, locked_out_a;
   logic [1:0]  fail_count_a;

   logic [15:0] mem_rd_data_b, mem_wr_data_b;
   logic [7:0]  mem_addr_b;
   logic        mem_wren_b, access_grant_b, locked_out_b;
   logic [1:0]  fail_count_b;

   int n_vec  = 0;
   int n_miss = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   access_ctrl_multi u_dut_a (
      .clk(clk), .rst(rst), .data_in(data_in), .data_in_load(data_in_load),
      .logout(logout), .mem_rd_data(mem_rd_data_a), .mem_addr(mem_addr_a),
      .mem_wren(mem_wren_a), .mem_wr_data(mem_wr_data_a),
      .access_grant(access_grant_a), .locked_out(locked_out_a),
      .fail_count(fail_count_a)
   );

   access_ctrl_multi #(.MEM_LAT(3)) u_dut_b (
      .clk(clk), .rst(rst), .data_in(data_in), .data_in_load(data_in_load),
      .logout(logout), .mem_rd_data(mem_rd_data_b), .mem_addr(mem_addr_b),
      .mem_wren(mem_wren_b), .mem_wr_data(mem_wr_data_b),
      .access_grant(access_grant_b), .locked_out(locked_out_b),
      .fail_count(fail_count_b)
   );

   // RAM models: only address 5 holds a password, every other address reads 0.
   logic [15:0] pw5_a = 16'h1234;
   logic [15:0] pw5_b = 16'h1234;
   logic [15:0] pipe_b0, pipe_b1;

   always @(posedge clk) begin
      if (mem_wren_a && mem_addr_a == 8'h05) pw5_a <= mem_wr_data_a;
      mem_rd_data_a <= (mem_addr_a == 8'h05) ? pw5_a : 16'h0;
      if (mem_wren_b && mem_addr_b == 8'h05) pw5_b <= mem_wr_data_b;
      pipe_b0       <= (mem_addr_b == 8'h05) ? pw5_b : 16'h0;
      pipe_b1       <= pipe_b0;
      mem_rd_data_b <= pipe_b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [15:0] w);
      data_in      = w;
      data_in_load = 1'b1;
      tick();
      data_in_load = 1'b0;
   endtask

   task automatic pulse_logout();
      logout = 1'b1;
      tick();
      logout = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Drives header+password and measures cycles from password edge to first grant.
   task automatic login(input logic [15:0] hdr, input logic [15:0] pw,
                        output int lat_a, output int lat_b);
      int n;
      lat_a = 99;
      lat_b = 99;
      load_word(hdr);
      load_word(pw);
      n = 0;
      while ((lat_a == 99 || lat_b == 99) && n < 12) begin
         tick();
         n++;
         if (lat_a == 99 && access_grant_a) lat_a = n;
         if (lat_b == 99 && access_grant_b) lat_b = n;
      end
   endtask

   task automatic test_reset();
      exp_q.push_back(0);
      pulse_reset();
      pulse_reset();
      n_vec++;
      if ({access_grant_a, locked_out_a, mem_wren_a, fail_count_a, mem_addr_a, mem_wr_data_a}
          !== 29'(exp_q.pop_front())) begin
         n_miss++;
         $display("FAIL reset_outputs got grant=%b lock=%b wren=%b fail=%0d addr=%h wd=%h want all 0",
                  access_grant_a, locked_out_a, mem_wren_a, fail_count_a, mem_addr_a, mem_wr_data_a);
      end
   endtask

   task automatic test_correct_pw();
      int la, lb;
      exp_q.push_back(3);
      login(16'h0005, 16'h1234, la, lb);
      n_vec++;
      if (la !== exp_q.pop_front()) begin
         n_miss++;
         $display("FAIL grant_latency got %0d want 3", la);
      end
      load_word(16'h0007);
      tick();
      n_vec++;
      if (access_grant_a !== 1'b1 || mem_addr_a !== 8'h05) begin
         n_miss++;
         $display("FAIL grant_hold got grant=%b addr=%h want grant=1 addr=05", access_grant_a, mem_addr_a);
      end
      pulse_logout();
      n_vec++;
      if (access_grant_a !== 1'b0) begin
         n_miss++;
         $display("FAIL logout got grant=%b want 0", access_grant_a);
      end
   endtask

   task automatic test_retry();
      int la, lb;
      load_word(16'h0005);
      load_word(16'h1111);
      tick();
      tick();
      n_vec++;
      if (fail_count_a !== 2'd0) begin
         n_miss++;
         $display("FAIL retry_before_check got fail=%0d want 0", fail_count_a);
      end
      tick();
      n_vec++;
      if (fail_count_a !== 2'd1 || access_grant_a !== 1'b0) begin
         n_miss++;
         $display("FAIL retry_mismatch got fail=%0d grant=%b want fail=1 grant=0", fail_count_a, access_grant_a);
      end
      exp_q.push_back(3);
      load_word(16'h1234);
      la = 0;
      while (!access_grant_a && la < 12) begin
         tick();
         la++;
      end
      n_vec++;
      if (la !== exp_q.pop_front() || fail_count_a !== 2'd0) begin
         n_miss++;
         $display("FAIL retry_match got latency=%0d fail=%0d want latency=3 fail=0", la, fail_count_a);
      end
      pulse_logout();
   endtask

   // Three wrong passwords; returns with locked_out freshly high.
   task automatic enter_lockout();
      load_word(16'h0005);
      for (int i = 0; i < 3; i++) begin
         load_word(16'h2222 + 16'(i));
         tick();
         tick();
         tick();
      end
   endtask

   task automatic test_lockout();
      int cnt, la, lb;
      enter_lockout();
      n_vec++;
      if (locked_out_a !== 1'b1 || fail_count_a !== 2'd3) begin
         n_miss++;
         $display("FAIL lockout_entry got lock=%b fail=%0d want lock=1 fail=3", locked_out_a, fail_count_a);
      end
      exp_q.push_back(1024);
      cnt = 0;
      while (locked_out_a && cnt < 2000) begin
         cnt++;
         data_in      = 16'h0005;
         data_in_load = (cnt % 100 == 50);
         logout       = (cnt % 100 == 70);
         tick();
      end
      data_in_load = 1'b0;
      logout       = 1'b0;
      n_vec++;
      if (cnt !== exp_q.pop_front()) begin
         n_miss++;
         $display("FAIL lockout_length got %0d want 1024", cnt);
      end
      n_vec++;
      if (fail_count_a !== 2'd0 || access_grant_a !== 1'b0) begin
         n_miss++;
         $display("FAIL lockout_exit got fail=%0d grant=%b want 0 0", fail_count_a, access_grant_a);
      end
      login(16'h0005, 16'h1234, la, lb);
      n_vec++;
      if (la !== 3) begin
         n_miss++;
         $display("FAIL post_lockout_login got %0d want 3", la);
      end
      pulse_logout();
   endtask

   task automatic test_reset_mid();
      int la, lb;
      load_word(16'h0005);
      load_word(16'h1234);
      pulse_reset();
      n_vec++;
      if ({access_grant_a, locked_out_a, mem_wren_a, fail_count_a, mem_addr_a} !== 13'd0) begin
         n_miss++;
         $display("FAIL reset_wait_mem got grant=%b lock=%b fail=%0d addr=%h want all 0",
                  access_grant_a, locked_out_a, fail_count_a, mem_addr_a);
      end
      repeat (5) tick();
      n_vec++;
      if (access_grant_a !== 1'b0) begin
         n_miss++;
         $display("FAIL reset_no_grant got grant=%b want 0", access_grant_a);
      end
      login(16'h0005, 16'h1234, la, lb);
      n_vec++;
      if (la !== 3) begin
         n_miss++;
         $display("FAIL reset_fresh_login got %0d want 3", la);
      end
      pulse_logout();
      enter_lockout();
      repeat (523) tick();
      pulse_reset();
      n_vec++;
      if ({access_grant_a, locked_out_a, mem_wren_a, fail_count_a, mem_addr_a} !== 13'd0) begin
         n_miss++;
         $display("FAIL reset_lockout got grant=%b lock=%b fail=%0d addr=%h want all 0",
                  access_grant_a, locked_out_a, fail_count_a, mem_addr_a);
      end
      login(16'h0005, 16'h1234, la, lb);
      n_vec++;
      if (la !== 3) begin
         n_miss++;
         $display("FAIL reset_lockout_login got %0d want 3", la);
      end
      pulse_logout();
   endtask

   task automatic test_latency();
      int la, lb;
      pulse_reset();
      exp_q.push_back(3);
      exp_q.push_back(5);
      login(16'h0005, 16'h1234, la, lb);
      n_vec++;
      if (la !== exp_q.pop_front()) begin
         n_miss++;
         $display("FAIL latency_lat1 got %0d want 3", la);
      end
      n_vec++;
      if (lb !== exp_q.pop_front()) begin
         n_miss++;
         $display("FAIL latency_lat3 got %0d want 5", lb);
      end
      pulse_logout();
   endtask

   task automatic change_pw(input logic [15:0] old_pw, input logic [15:0] new_pw);
      load_word(16'h0105);
      load_word(old_pw);
      repeat (3) tick();
      n_vec++;
      if (access_grant_a !== 1'b0 || mem_wren_a !== 1'b0) begin
         n_miss++;
         $display("FAIL change_wait got grant=%b wren=%b want 0 0", access_grant_a, mem_wren_a);
      end
      load_word(new_pw);
      n_vec++;
      if (mem_wren_a !== 1'b1 || mem_addr_a !== 8'h05 || mem_wr_data_a !== new_pw) begin
         n_miss++;
         $display("FAIL change_write got wren=%b addr=%h wd=%h want 1 05 %h",
                  mem_wren_a, mem_addr_a, mem_wr_data_a, new_pw);
      end
      tick();
      n_vec++;
      if (mem_wren_a !== 1'b0 || mem_wr_data_a !== new_pw || access_grant_a !== 1'b0) begin
         n_miss++;
         $display("FAIL change_after got wren=%b wd=%h grant=%b want 0 %h 0",
                  mem_wren_a, mem_wr_data_a, access_grant_a, new_pw);
      end
   endtask

   task automatic test_change();
      int la, lb;
      change_pw(16'h1234, 16'hBEEF);
      pulse_logout();
      n_vec++;
      if (access_grant_a !== 1'b0) begin
         n_miss++;
         $display("FAIL logout_idle got grant=%b want 0", access_grant_a);
      end
      login(16'h0005, 16'hBEEF, la, lb);
      n_vec++;
      if (la !== 3) begin
         n_miss++;
         $display("FAIL change_login got %0d want 3", la);
      end
      pulse_logout();
      change_pw(16'hBEEF, 16'h0000);
      login(16'h0005, 16'h0000, la, lb);
      n_vec++;
      if (la !== 3) begin
         n_miss++;
         $display("FAIL zero_pw_login got %0d want 3", la);
      end
      pulse_logout();
   endtask

   initial begin
      test_reset();
      test_correct_pw();
      test_retry();
      test_lockout();
      test_reset_mid();
      test_latency();
      test_change();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
